sample_frame_dispatcher: RTL and testbench

//  Successor to the single-buffer RAM readout stage in front of the processing-unit array.
//  - Collects a serial stream of per-channel samples into NUM_CH-wide frames.
//  - Ping-pong buffering: collection never stalls while the previous frame is being consumed.
//  - Presents each complete frame to the processing units over a valid/ready handshake.
//  - Adds frame-sync realignment, overflow/drop accounting and frame counters.

---
 rtl/sample_frame_dispatcher.sv | 114 +++++++++++
 tb/tb_sample_frame_dispatcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_dispatcher.sv
// sample_frame_dispatcher
// Packs a serial per-channel sample stream into NUM_CH-wide frames held in two
// ping-pong banks. One bank fills while the other is offered to the consumer
// over a valid/ready handshake. Also handles frame-sync realignment, drops when
// both banks are busy, and keeps accepted/dropped frame counters.
module sample_frame_dispatcher #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int CNT_W      = 16,
  localparam int PTR_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        sample_in,
  input  logic                         sample_wr,
  input  logic                         frame_sync,
  output logic [NUM_CH*DATA_WIDTH-1:0] frame_out,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [PTR_W-1:0]             ch_ptr,
  output logic                         overflow,
  output logic                         sync_err,
  input  logic                         err_clr,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic [7:0]                   drop_cnt
);

  logic [DATA_WIDTH-1:0] bank_q [2][NUM_CH];
  logic [PTR_W-1:0]      ch_ptr_q, ch_ptr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  pending_q, pending_d;
  logic                  overflow_q, overflow_d;
  logic                  sync_err_q, sync_err_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic [PTR_W-1:0]      idx;
  logic                  last_ch;
  logic                  accept;
  logic                  complete;
  logic                  swap;
  logic                  drop;

  // Next-state logic: write index, frame completion, swap-or-drop decision, sticky flags, counters
  always_comb begin
    idx        = frame_sync ? '0 : ch_ptr_q;
    last_ch    = (idx == PTR_W'(NUM_CH - 1));
    accept     = pending_q & frame_ready;
    complete   = sample_wr & last_ch;
    // The held frame may be replaced only if nothing is held or it leaves this very edge
    swap       = complete & (~pending_q | accept);
    drop       = complete & ~swap;

    ch_ptr_d   = ch_ptr_q;
    if (sample_wr) begin
      ch_ptr_d = last_ch ? '0 : idx + PTR_W'(1);
    end

    wr_bank_d  = wr_bank_q ^ swap;
    pending_d  = swap ? 1'b1 : (accept ? 1'b0 : pending_q);

    // Set has priority over a same-cycle clear so no event is lost
    overflow_d = drop | (overflow_q & ~err_clr);
    sync_err_d = (sample_wr & frame_sync & (ch_ptr_q != '0)) | (sync_err_q & ~err_clr);

    frame_cnt_d = accept ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
    drop_cnt_d  = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // State registers and sample storage; reset discards partial and pending frames
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NUM_CH; k++) begin
          bank_q[b][k] <= '0;
        end
      end
      ch_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (sample_wr) begin
        bank_q[wr_bank_q][idx] <= sample_in;
      end
      ch_ptr_q    <= ch_ptr_d;
      wr_bank_q   <= wr_bank_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // The bank not being filled is the one presented to the consumer
  always_comb begin
    frame_out = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      frame_out[k*DATA_WIDTH +: DATA_WIDTH] = bank_q[~wr_bank_q][k];
    end
  end

  assign frame_valid = pending_q;
  assign ch_ptr      = ch_ptr_q;
  assign overflow    = overflow_q;
  assign sync_err    = sync_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_sample_frame_dispatcher.sv
// Bench for sample_frame_dispatcher: a 4-channel and a 1-channel instance share
// the same stimulus; a frame-level reference model is checked every cycle.
module tb_sample_frame_dispatcher;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sample_wr, frame_sync, frame_ready, err_clr;
  logic [DW-1:0] sample_in;

  logic [NCH*DW-1:0] frame_out;
  logic              frame_valid, overflow, sync_err;
  logic [1:0]        ch_ptr;
  logic [CW-1:0]     frame_cnt;
  logic [7:0]        drop_cnt;

  logic [DW-1:0] f1_out;
  logic          f1_valid, f1_ovf, f1_serr;
  logic [0:0]    f1_ptr;
  logic [CW-1:0] f1_cnt;
  logic [7:0]    f1_drop;

  sample_frame_dispatcher #(.NUM_CH(NCH), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_wr(sample_wr),
    .frame_sync(frame_sync), .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .ch_ptr(ch_ptr), .overflow(overflow),
    .sync_err(sync_err), .err_clr(err_clr), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));

  sample_frame_dispatcher #(.NUM_CH(1), .DATA_WIDTH(DW), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_wr(sample_wr),
    .frame_sync(frame_sync), .frame_out(f1_out), .frame_valid(f1_valid),
    .frame_ready(frame_ready), .ch_ptr(f1_ptr), .overflow(f1_ovf),
    .sync_err(f1_serr), .err_clr(err_clr), .frame_cnt(f1_cnt), .drop_cnt(f1_drop));

  int errs   = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model, 4 channels: current partial frame, frame on display, flags, counts
  int            m_ptr, m_idx, m_drop;
  logic [DW-1:0] m_cur [NCH];
  logic [DW-1:0] m_show[NCH];
  bit            m_pend, m_ovf, m_serr, m_acc, m_nxt, m_oset, m_sset;
  logic [CW-1:0] m_cnt;
  // Reference model, 1 channel
  logic [DW-1:0] s1;
  logic [CW-1:0] c1;
  bit            p1, o1, a1, n1, os1;
  int            d1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ptr = 0; m_pend = 0; m_ovf = 0; m_serr = 0; m_cnt = '0; m_drop = 0;
      for (int k = 0; k < NCH; k++) begin m_cur[k] = '0; m_show[k] = '0; end
      s1 = '0; c1 = '0; p1 = 0; o1 = 0; d1 = 0;
    end else begin
      m_acc = m_pend && frame_ready;
      if (m_acc) m_cnt = m_cnt + 1'b1;
      m_nxt = m_acc ? 1'b0 : m_pend;
      m_oset = 0; m_sset = 0;
      if (sample_wr) begin
        m_idx = frame_sync ? 0 : m_ptr;
        if (frame_sync && m_ptr != 0) m_sset = 1;
        m_cur[m_idx] = sample_in;
        if (m_idx == NCH - 1) begin
          m_ptr = 0;
          if (!m_pend || m_acc) begin
            for (int k = 0; k < NCH; k++) m_show[k] = m_cur[k];
            m_nxt = 1;
          end else begin
            m_oset = 1;
            if (m_drop < 255) m_drop++;
          end
        end else begin
          m_ptr = m_idx + 1;
        end
      end
      m_ovf  = m_oset | (m_ovf & !err_clr);
      m_serr = m_sset | (m_serr & !err_clr);
      m_pend = m_nxt;

      a1 = p1 && frame_ready;
      if (a1) c1 = c1 + 1'b1;
      n1 = a1 ? 1'b0 : p1;
      os1 = 0;
      if (sample_wr) begin
        if (!p1 || a1) begin s1 = sample_in; n1 = 1; end
        else begin os1 = 1; if (d1 < 255) d1++; end
      end
      o1 = os1 | (o1 & !err_clr);
      p1 = n1;
    end
  end

  // Compare both instances against the model every cycle on the falling edge
  logic [NCH*DW-1:0] ev;
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NCH; k++) ev[k*DW +: DW] = m_show[k];
      chk("frame_out",   64'(frame_out),   64'(ev));
      chk("frame_valid", 64'(frame_valid), 64'(m_pend));
      chk("ch_ptr",      64'(ch_ptr),      64'(m_ptr));
      chk("overflow",    64'(overflow),    64'(m_ovf));
      chk("sync_err",    64'(sync_err),    64'(m_serr));
      chk("frame_cnt",   64'(frame_cnt),   64'(m_cnt));
      chk("drop_cnt",    64'(drop_cnt),    64'(m_drop));
      chk("n1_frame_out", 64'(f1_out),   64'(s1));
      chk("n1_valid",     64'(f1_valid), 64'(p1));
      chk("n1_ch_ptr",    64'(f1_ptr),   64'd0);
      chk("n1_overflow",  64'(f1_ovf),   64'(o1));
      chk("n1_sync_err",  64'(f1_serr),  64'd0);
      chk("n1_frame_cnt", 64'(f1_cnt),   64'(c1));
      chk("n1_drop_cnt",  64'(f1_drop),  64'(d1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit s);
    sample_in = d; sample_wr = 1'b1; frame_sync = s;
    cyc();
    sample_wr = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sample_wr = 1'b0; frame_sync = 1'b0; frame_ready = 1'b0;
    err_clr = 1'b0; sample_in = '0;

    // T1: reset state, then first frame
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame", 64'(frame_out), 64'd0);
    chk("rst_ptr",   64'(ch_ptr), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_serr",  64'(sync_err), 64'd0);
    chk("rst_cnt",   64'(frame_cnt), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    wr(16'h0011, 0); wr(16'h0022, 0); wr(16'h0033, 0);
    chk("t1_valid_early", 64'(frame_valid), 64'd0);
    wr(16'h0044, 0);
    chk("t1_valid", 64'(frame_valid), 64'd1);
    chk("t1_frame", 64'(frame_out), 64'h0044_0033_0022_0011);

    // T2: held frame stable while not ready, then one accept
    repeat (5) begin
      cyc();
      chk("t2_hold", 64'(frame_out), 64'h0044_0033_0022_0011);
    end
    frame_ready = 1'b1;
    cyc();
    frame_ready = 1'b0;
    chk("t2_valid_drop", 64'(frame_valid), 64'd0);
    chk("t2_cnt", 64'(frame_cnt), 64'd1);

    // T3: overflow with consumer stalled, then clear
    do_reset();
    for (int i = 0; i < 12; i++) wr(16'(16'h0100 + i), 0);
    chk("t3_ovf",   64'(overflow), 64'd1);
    chk("t3_drop",  64'(drop_cnt), 64'd2);
    chk("t3_frame", 64'(frame_out), 64'h0103_0102_0101_0100);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t3_clr", 64'(overflow), 64'd0);
    // drop counter saturates
    for (int i = 0; i < 4 * 260; i++) wr(16'(i), 0);
    chk("t3_drop_sat", 64'(drop_cnt), 64'd255);

    // T4: frame sync mid-frame realigns to channel 0
    do_reset();
    wr(16'h0001, 0); wr(16'h0002, 0);
    wr(16'h00AA, 1);
    chk("t4_serr", 64'(sync_err), 64'd1);
    chk("t4_ptr",  64'(ch_ptr), 64'd1);
    chk("t4_n1_serr", 64'(f1_serr), 64'd0);
    wr(16'h00B1, 0); wr(16'h00B2, 0); wr(16'h00B3, 0);
    chk("t4_valid", 64'(frame_valid), 64'd1);
    chk("t4_frame", 64'(frame_out), 64'h00B3_00B2_00B1_00AA);

    // T5: continuous streaming with ready held high
    do_reset();
    frame_ready = 1'b1;
    sample_wr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      sample_in = 16'(i);
      cyc();
      if (i % 4 == 3)
        chk("t5_frame", 64'(frame_out),
            {16'(i), 16'(i - 1), 16'(i - 2), 16'(i - 3)});
    end
    sample_wr = 1'b0;
    cyc(); cyc();
    chk("t5_cnt",  64'(frame_cnt), 64'd100);
    chk("t5_drop", 64'(drop_cnt), 64'd0);
    frame_ready = 1'b0;

    // T6: reset with a pending frame and a partial frame
    do_reset();
    for (int i = 0; i < 6; i++) wr(16'(16'h0021 + i), 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t6_valid", 64'(frame_valid), 64'd0);
    chk("t6_ptr",   64'(ch_ptr), 64'd0);
    chk("t6_cnt",   64'(frame_cnt), 64'd0);
    chk("t6_drop",  64'(drop_cnt), 64'd0);
    chk("t6_zero",  64'(frame_out), 64'd0);
    wr(16'h0031, 0); wr(16'h0032, 0); wr(16'h0033, 0); wr(16'h0034, 0);
    chk("t6_valid2", 64'(frame_valid), 64'd1);
    chk("t6_frame",  64'(frame_out), 64'h0034_0033_0032_0031);

    // T7: randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      sample_wr   = ($urandom_range(0, 9) < 7);
      frame_sync  = sample_wr && ($urandom_range(0, 9) == 0);
      sample_in   = 16'($urandom);
      frame_ready = ($urandom_range(0, 1) == 1);
      err_clr     = ($urandom_range(0, 19) == 0);
      rst_n       = ($urandom_range(0, 599) != 0);
      cyc();
    end
    sample_wr = 1'b0; frame_sync = 1'b0; err_clr = 1'b0; rst_n = 1'b1;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
